// File: rtl/das_sum.sv
// Delay-and-sum stage: paces the four-channel RF reader, delays each channel by a
// latched sample count and sums the taps. Optional macro DAS_APOD_EN adds per-channel
// apodization shifts (apod1..apod4).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; delays latched and history cleared on accept
// RUN    | inc_count high; issuing FRAME_LEN reader advances
// FLUSH  | reader done; waiting for the final capture's sum to register
module das_sum #(
  parameter int DATA_W    = 16,
  parameter int MAX_DLY   = 32,
  parameter int FRAME_LEN = 24100
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [$clog2(MAX_DLY)-1:0] dly1,
  input  logic [$clog2(MAX_DLY)-1:0] dly2,
  input  logic [$clog2(MAX_DLY)-1:0] dly3,
  input  logic [$clog2(MAX_DLY)-1:0] dly4,
`ifdef DAS_APOD_EN
  input  logic [1:0]                 apod1,
  input  logic [1:0]                 apod2,
  input  logic [1:0]                 apod3,
  input  logic [1:0]                 apod4,
`endif
  input  logic [DATA_W-1:0]          val1,
  input  logic [DATA_W-1:0]          val2,
  input  logic [DATA_W-1:0]          val3,
  input  logic [DATA_W-1:0]          val4,
  output logic                       inc_count,
  output logic [DATA_W+1:0]          sum_out,
  output logic                       sum_valid,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int DLY_W = $clog2(MAX_DLY);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int DEPTH = MAX_DLY - 1;
  localparam int SUM_W = DATA_W + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
  logic             cap_en_q;
  logic             sum_valid_q;
  logic             frame_done_q;
  logic             accept;
  logic             last_cap;

  logic        [DLY_W-1:0]  dly_in [4];
  logic        [DLY_W-1:0]  dly_q  [4];
  logic signed [DATA_W-1:0] val_in [4];
  logic signed [DATA_W-1:0] tap    [4];
  logic signed [DATA_W-1:0] line_q [4][DEPTH];
  logic signed [SUM_W-1:0]  sum_d, sum_q;

`ifdef DAS_APOD_EN
  logic [1:0] apod_in [4];
  logic [1:0] apod_q  [4];

  assign apod_in[0] = apod1;
  assign apod_in[1] = apod2;
  assign apod_in[2] = apod3;
  assign apod_in[3] = apod4;
`endif

  assign dly_in[0] = dly1;
  assign dly_in[1] = dly2;
  assign dly_in[2] = dly3;
  assign dly_in[3] = dly4;

  assign val_in[0] = $signed(val1);
  assign val_in[1] = $signed(val2);
  assign val_in[2] = $signed(val3);
  assign val_in[3] = $signed(val4);

  assign accept   = (state_q == S_IDLE) && start;
  assign last_cap = cap_en_q && (cap_cnt_q == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    inc_count   = 1'b0;
    busy        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
        end
      end
      S_RUN: begin
        inc_count   = 1'b1;
        busy        = 1'b1;
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
        if (issue_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (frame_done_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (cap_en_q) begin
      cap_cnt_d = cap_cnt_q + CNT_W'(1);
    end
  end

  // A delay of 0 taps the sample being captured now; d>0 taps history entry d-1.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (dly_q[i] == '0) begin
        tap[i] = val_in[i];
      end else begin
        tap[i] = line_q[i][dly_q[i] - DLY_W'(1)];
      end
`ifdef DAS_APOD_EN
      tap[i] = tap[i] >>> apod_q[i];
`endif
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 4; i++) begin
      sum_d = sum_d + SUM_W'(tap[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        dly_q[i] <= '0;
`ifdef DAS_APOD_EN
        apod_q[i] <= '0;
`endif
        for (int j = 0; j < DEPTH; j++) begin
          line_q[i][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < 4; i++) begin
        dly_q[i] <= dly_in[i];
`ifdef DAS_APOD_EN
        apod_q[i] <= apod_in[i];
`endif
        for (int j = 0; j < DEPTH; j++) begin
          line_q[i][j] <= '0;
        end
      end
    end else if (cap_en_q) begin
      for (int i = 0; i < 4; i++) begin
        line_q[i][0] <= val_in[i];
        for (int j = 1; j < DEPTH; j++) begin
          line_q[i][j] <= line_q[i][j-1];
        end
      end
    end
  end

  // The reader registers its read, so data for an advance arrives one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_en_q     <= 1'b0;
      sum_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sum_q        <= '0;
    end else begin
      cap_en_q     <= inc_count;
      sum_valid_q  <= cap_en_q;
      frame_done_q <= last_cap;
      if (cap_en_q) begin
        sum_q <= sum_d;
      end
    end
  end

  assign sum_out    = sum_q;
  assign sum_valid  = sum_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_das_sum.sv
// Directed bench for das_sum with a small frame and a registered-read reader model.
module tb_das_sum;
  localparam int DATA_W    = 16;
  localparam int MAX_DLY   = 8;
  localparam int FRAME_LEN = 16;
  localparam int DLY_W     = $clog2(MAX_DLY);
  localparam int IDX_W     = $clog2(FRAME_LEN);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [DLY_W-1:0]  dly1 = '0, dly2 = '0, dly3 = '0, dly4 = '0;
  logic [DATA_W-1:0] val1, val2, val3, val4;
  logic              inc_count;
  logic [DATA_W+1:0] sum_out;
  logic              sum_valid, frame_done, busy;
`ifdef DAS_APOD_EN
  logic [1:0] apod1 = '0, apod2 = '0, apod3 = '0, apod4 = '0;
`endif

  das_sum #(.DATA_W(DATA_W), .MAX_DLY(MAX_DLY), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .dly1(dly1), .dly2(dly2), .dly3(dly3), .dly4(dly4),
`ifdef DAS_APOD_EN
    .apod1(apod1), .apod2(apod2), .apod3(apod3), .apod4(apod4),
`endif
    .val1(val1), .val2(val2), .val3(val3), .val4(val4),
    .inc_count(inc_count), .sum_out(sum_out), .sum_valid(sum_valid),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] rf [4][FRAME_LEN];
  logic [IDX_W-1:0]  rd_idx;

  // Reader: registered read, wraps at frame length.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_idx <= '0;
      val1 <= '0; val2 <= '0; val3 <= '0; val4 <= '0;
    end else if (inc_count) begin
      val1 <= rf[0][rd_idx];
      val2 <= rf[1][rd_idx];
      val3 <= rf[2][rd_idx];
      val4 <= rf[3][rd_idx];
      rd_idx <= (rd_idx == IDX_W'(FRAME_LEN - 1)) ? '0 : rd_idx + IDX_W'(1);
    end
  end

  int exp_sum [FRAME_LEN];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic set_const(input int a, input int b, input int c, input int d);
    for (int i = 0; i < FRAME_LEN; i++) begin
      rf[0][i] = 16'(a); rf[1][i] = 16'(b); rf[2][i] = 16'(c); rf[3][i] = 16'(d);
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < FRAME_LEN; i++)
      for (int ch = 0; ch < 4; ch++) rf[ch][i] = 16'(i);
  endtask

  task automatic set_dly(input int a, input int b, input int c, input int d);
    dly1 = DLY_W'(a); dly2 = DLY_W'(b); dly3 = DLY_W'(c); dly4 = DLY_W'(d);
  endtask

  task automatic exp_const(input int v);
    for (int k = 0; k < FRAME_LEN; k++) exp_sum[k] = v;
  endtask

  // Ramp with delays 0,1,2,3: 0, 1, 3, then 4k-6.
  task automatic exp_ramp();
    for (int k = 0; k < FRAME_LEN; k++)
      exp_sum[k] = (k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 3 : 4 * k - 6;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"},  int'(busy), 0);
    check({name, "_inc"},   int'(inc_count), 0);
    check({name, "_valid"}, int'(sum_valid), 0);
    check({name, "_done"},  int'(frame_done), 0);
  endtask

  // Called at a negedge; start is sampled at the next posedge (cycle s).
  // Returns at the negedge of cycle s+FRAME_LEN+2.
  task automatic run_frame(input bit mid_start, input string name);
    logic [DLY_W-1:0] sv1, sv2, sv3, sv4;
    sv1 = dly1; sv2 = dly2; sv3 = dly3; sv4 = dly4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= FRAME_LEN + 2; c++) begin
      check($sformatf("%s_busy[%0d]", name, c),  int'(busy), 1);
      check($sformatf("%s_inc[%0d]", name, c),   int'(inc_count), (c <= FRAME_LEN) ? 1 : 0);
      check($sformatf("%s_valid[%0d]", name, c), int'(sum_valid), (c >= 3) ? 1 : 0);
      check($sformatf("%s_done[%0d]", name, c),  int'(frame_done), (c == FRAME_LEN + 2) ? 1 : 0);
      if (c >= 3)
        check($sformatf("%s_sum[%0d]", name, c - 3), int'($signed(sum_out)), exp_sum[c-3]);
      if (mid_start && c == 5) begin
        start = 1'b1;
        set_dly(7, 7, 7, 7);
      end
      if (mid_start && c == 6) begin
        start = 1'b0;
        dly1 = sv1; dly2 = sv2; dly3 = sv3; dly4 = sv4;
      end
      if (c < FRAME_LEN + 2) @(negedge clk);
    end
  endtask

  initial begin
    set_const(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_inc",   int'(inc_count), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_valid", int'(sum_valid), 0);
    check("rst_done",  int'(frame_done), 0);
    check("rst_sum",   int'($signed(sum_out)), 0);
    reset_n = 1'b1;
    @(negedge clk);

    set_dly(0, 0, 0, 0);
    set_const(100, 200, -50, 7);
    exp_const(257);
    run_frame(1'b0, "zero");
    @(negedge clk);
    check_quiet("zero_end");

    set_dly(0, 1, 2, 3);
    set_ramp();
    exp_ramp();
    run_frame(1'b1, "dly");
    @(negedge clk);
    check_quiet("dly_end");

    set_dly(0, 0, 0, 0);
    set_const(100, 200, -50, 7);
    exp_const(257);
    run_frame(1'b0, "b2b");
    @(negedge clk);

    set_const(32767, 32767, 32767, 32767);
    exp_const(131068);
    run_frame(1'b0, "max");
    @(negedge clk);

    set_const(-32768, -32768, -32768, -32768);
    exp_const(-131072);
    run_frame(1'b0, "min");
    @(negedge clk);

    set_dly(0, 1, 2, 3);
    set_ramp();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mrst_inc",   int'(inc_count), 0);
    check("mrst_busy",  int'(busy), 0);
    check("mrst_valid", int'(sum_valid), 0);
    check("mrst_done",  int'(frame_done), 0);
    check("mrst_sum",   int'($signed(sum_out)), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_ramp();
    run_frame(1'b0, "post_rst");
    @(negedge clk);
    check_quiet("post_rst_end");

`ifdef DAS_APOD_EN
    set_dly(0, 0, 0, 0);
    apod1 = 2'd1; apod2 = 2'd0; apod3 = 2'd2; apod4 = 2'd3;
    set_const(64, 64, 64, 64);
    exp_const(120);
    run_frame(1'b0, "apod");
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
